prio_enc_queue: RTL and testbench

Parametrised, registered successor to the 4:2 combinational priority encoder. It captures an N-bit request vector with a valid/ready handshake and drains every set bit as one encoded index per output handshake. Ordering is either fixed priority (highest index first) or round-robin across batches. It sits between request sources (interrupt lines, channel requests) and a single downstream consumer that services one index at a time.

---
 rtl/prio_enc_queue.sv | 136 +++++++++++++
 tb/tb_prio_enc_queue.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/prio_enc_queue.sv
// Registered priority-encoder queue: captures an N-bit request vector and drains
// each set bit as one encoded index per output handshake (fixed or round-robin).
module prio_enc_queue #(
   parameter int N    = 8,
   parameter int W    = $clog2(N),
   parameter int MODE = 0
) (
   input  logic         Clk,
   input  logic         Rst_n,
   input  logic [N-1:0] Inp,
   input  logic         InValid,
   output logic         InReady,
   input  logic         Clear,
   output logic [W-1:0] Out,
   output logic         OutValid,
   input  logic         OutReady,
   output logic         ZeroFlag,
   output logic [W:0]   PendCount
);

   typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

   state_t       state_q, state_d;
   logic [N-1:0] pend_q, pend_d;
   logic [W-1:0] out_q, out_d;
   logic         out_valid_q, out_valid_d;
   logic [W-1:0] last_grant_q, last_grant_d;
   logic         zero_flag_q, zero_flag_d;
   logic [W:0]   pend_count_q, pend_count_d;
   logic [N-1:0] rem;

   // Round-robin walks last-1 down to 0, then N-1 down to last. Later hits in the
   // loop override earlier ones, so k=1 (nearest below last) has top priority.
   // The wrap adds N, so unused codes N..2^W-1 are never produced.
   function automatic logic [W-1:0] sel(input logic [N-1:0] v, input logic [W-1:0] last);
      logic [W-1:0] r;
      logic [W-1:0] idx;
      int           t;
      r = '0;
      if (MODE == 0) begin
         for (int i = 0; i < N; i++)
            if (v[i]) r = W'(i);
      end else begin
         for (int k = N; k >= 1; k--) begin
            t = int'(last) - k;
            if (t < 0) t = t + N;
            idx = W'(t);
            if (v[idx]) r = idx;
         end
      end
      return r;
   endfunction

   function automatic logic [W:0] popcount(input logic [N-1:0] v);
      logic [W:0] c;
      c = '0;
      for (int i = 0; i < N; i++) c = c + (W+1)'(v[i]);
      return c;
   endfunction

   assign rem = pend_q & ~({{(N-1){1'b0}}, 1'b1} << out_q);

   always_comb begin
      state_d      = state_q;
      pend_d       = pend_q;
      out_d        = out_q;
      out_valid_d  = out_valid_q;
      last_grant_d = last_grant_q;
      zero_flag_d  = 1'b0;
      pend_count_d = pend_count_q;
      if (Clear) begin
         state_d      = IDLE;
         pend_d       = '0;
         out_valid_d  = 1'b0;
         pend_count_d = '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (InValid) begin
                  if (|Inp) begin
                     pend_d       = Inp;
                     out_d        = sel(Inp, last_grant_q);
                     out_valid_d  = 1'b1;
                     pend_count_d = popcount(Inp);
                     state_d      = BUSY;
                  end else begin
                     zero_flag_d = 1'b1;
                  end
               end
            end
            BUSY: begin
               if (out_valid_q && OutReady) begin
                  pend_d       = rem;
                  last_grant_d = out_q;
                  pend_count_d = pend_count_q - 1'b1;
                  // next grant searches from the index just granted: no bubble
                  if (|rem) begin
                     out_d = sel(rem, out_q);
                  end else begin
                     out_valid_d = 1'b0;
                     state_d     = IDLE;
                  end
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         state_q      <= IDLE;
         pend_q       <= '0;
         out_q        <= '0;
         out_valid_q  <= 1'b0;
         last_grant_q <= '0;
         zero_flag_q  <= 1'b0;
         pend_count_q <= '0;
      end else begin
         state_q      <= state_d;
         pend_q       <= pend_d;
         out_q        <= out_d;
         out_valid_q  <= out_valid_d;
         last_grant_q <= last_grant_d;
         zero_flag_q  <= zero_flag_d;
         pend_count_q <= pend_count_d;
      end
   end

   assign InReady   = (state_q == IDLE);
   assign Out       = out_q;
   assign OutValid  = out_valid_q;
   assign ZeroFlag  = zero_flag_q;
   assign PendCount = pend_count_q;

endmodule

// File: tb/tb_prio_enc_queue.sv
// Bench for prio_enc_queue: three instances (N=8 fixed, N=4 round-robin,
// N=5 round-robin) checked against a queue of model-predicted grants.
module tb_prio_enc_queue;

   logic       Clk = 1'b0;
   logic       rst_n;
   logic [7:0] inp    [3];
   logic       inv    [3];
   logic       oready [3];
   logic       clr    [3];
   logic [7:0] out_w  [3];
   logic [7:0] pc     [3];
   logic       ov     [3];
   logic       ir     [3];
   logic       zf     [3];

   logic [2:0] a_out; logic [3:0] a_pc;
   logic [1:0] b_out; logic [2:0] b_pc;
   logic [2:0] c_out; logic [3:0] c_pc;

   int checks = 0;
   int errors = 0;
   int nn [3] = '{8, 4, 5};
   int mm [3] = '{0, 1, 1};
   int model_last [3] = '{0, 0, 0};

   typedef struct {int idx; int cnt;} exp_t;
   exp_t q[$];

   always #5 Clk = ~Clk;

   prio_enc_queue #(.N(8), .MODE(0)) u_a (
      .Clk(Clk), .Rst_n(rst_n), .Inp(inp[0]), .InValid(inv[0]), .InReady(ir[0]),
      .Clear(clr[0]), .Out(a_out), .OutValid(ov[0]), .OutReady(oready[0]),
      .ZeroFlag(zf[0]), .PendCount(a_pc));
   prio_enc_queue #(.N(4), .MODE(1)) u_b (
      .Clk(Clk), .Rst_n(rst_n), .Inp(inp[1][3:0]), .InValid(inv[1]), .InReady(ir[1]),
      .Clear(clr[1]), .Out(b_out), .OutValid(ov[1]), .OutReady(oready[1]),
      .ZeroFlag(zf[1]), .PendCount(b_pc));
   prio_enc_queue #(.N(5), .MODE(1)) u_c (
      .Clk(Clk), .Rst_n(rst_n), .Inp(inp[2][4:0]), .InValid(inv[2]), .InReady(ir[2]),
      .Clear(clr[2]), .Out(c_out), .OutValid(ov[2]), .OutReady(oready[2]),
      .ZeroFlag(zf[2]), .PendCount(c_pc));

   assign out_w[0] = {5'b0, a_out};
   assign out_w[1] = {6'b0, b_out};
   assign out_w[2] = {5'b0, c_out};
   assign pc[0]    = {4'b0, a_pc};
   assign pc[1]    = {5'b0, b_pc};
   assign pc[2]    = {4'b0, c_pc};

   // reference selection: walk the search order one step at a time
   function automatic int model_sel(input logic [7:0] v, input int n, input int mode, input int last);
      int idx;
      if (mode == 0) begin
         for (int i = n - 1; i >= 0; i--) if (v[i]) return i;
         return -1;
      end
      idx = last;
      for (int s = 0; s < n; s++) begin
         idx = (idx == 0) ? n - 1 : idx - 1;
         if (v[idx]) return idx;
      end
      return -1;
   endfunction

   task automatic push_batch(input int d, input logic [7:0] v);
      int   last, cnt, g;
      exp_t e;
      last = model_last[d];
      cnt  = $countones(v);
      while (v != 8'h00 && cnt > 0) begin
         g = model_sel(v, nn[d], mm[d], last);
         e.idx = g; e.cnt = cnt;
         q.push_back(e);
         v[g] = 1'b0;
         cnt--;
         last = g;
      end
   endtask

   // entered and left on a negative edge
   task automatic accept(input int d, input logic [7:0] v);
      checks++;
      if (ir[d] !== 1'b1) begin
         errors++;
         $display("FAIL accept_ready d%0d: InReady=%b want 1", d, ir[d]);
      end
      inp[d] = v; inv[d] = 1'b1;
      push_batch(d, v);
      @(negedge Clk);
      inv[d] = 1'b0;
      inp[d] = 8'($urandom);
   endtask

   task automatic drain(input int d, input int stall, input int stop_after);
      int cyc, pops, ei, ec;
      cyc = 0; pops = 0;
      while (q.size() > 0 && (stop_after < 0 || pops < stop_after)) begin
         oready[d] = (cyc >= stall);
         ei = q[0].idx; ec = q[0].cnt;
         checks++;
         if (ov[d] !== 1'b1 || out_w[d] !== 8'(ei) || pc[d] !== 8'(ec) || ir[d] !== 1'b0) begin
            errors++;
            $display("FAIL drain d%0d cyc%0d: got valid=%b out=%0d cnt=%0d inready=%b, want valid=1 out=%0d cnt=%0d inready=0",
                     d, cyc, ov[d], out_w[d], pc[d], ir[d], ei, ec);
         end
         if (oready[d]) begin
            model_last[d] = ei;
            void'(q.pop_front());
            pops++;
         end
         cyc++;
         @(negedge Clk);
         if (cyc > 100) begin
            errors++;
            $display("FAIL drain_timeout d%0d: %0d entries left, want 0", d, q.size());
            q.delete();
         end
      end
      oready[d] = 1'b0;
      if (stop_after < 0) begin
         checks++;
         if (ov[d] !== 1'b0 || pc[d] !== 8'd0 || ir[d] !== 1'b1) begin
            errors++;
            $display("FAIL turnaround d%0d: valid=%b cnt=%0d inready=%b, want 0 0 1", d, ov[d], pc[d], ir[d]);
         end
      end
   endtask

   task automatic test_reset;
      #12;
      for (int d = 0; d < 3; d++) begin
         checks++;
         if (ov[d] !== 1'b0 || pc[d] !== 8'd0 || out_w[d] !== 8'd0 || zf[d] !== 1'b0) begin
            errors++;
            $display("FAIL reset_state d%0d: valid=%b cnt=%0d out=%0d zero=%b, want all 0", d, ov[d], pc[d], out_w[d], zf[d]);
         end
      end
      @(negedge Clk); rst_n = 1'b1;
      @(negedge Clk);
      for (int d = 0; d < 3; d++) begin
         checks++;
         if (ir[d] !== 1'b1) begin
            errors++;
            $display("FAIL reset_inready d%0d: got %b want 1", d, ir[d]);
         end
      end
   endtask

   task automatic test_fixed_prio;
      accept(0, 8'b1010_0100);
      drain(0, 0, -1);
   endtask

   task automatic test_backpressure;
      accept(0, 8'b1010_0100);
      drain(0, 5, -1);
   endtask

   task automatic test_back_to_back;
      accept(0, 8'h81);
      drain(0, 0, -1);
      accept(0, 8'h18);
      drain(0, 0, -1);
   endtask

   task automatic test_round_robin;
      accept(1, 8'h08); drain(1, 0, -1);
      accept(1, 8'h09); drain(1, 0, -1);
      accept(1, 8'h09); drain(1, 2, -1);
   endtask

   task automatic test_zero;
      checks++;
      if (ir[0] !== 1'b1) begin errors++; $display("FAIL zero_ready_pre: got %b want 1", ir[0]); end
      inp[0] = 8'h00; inv[0] = 1'b1;
      @(negedge Clk);
      inv[0] = 1'b0;
      checks++;
      if (zf[0] !== 1'b1 || ov[0] !== 1'b0 || ir[0] !== 1'b1) begin
         errors++;
         $display("FAIL zero_pulse: zero=%b valid=%b inready=%b, want 1 0 1", zf[0], ov[0], ir[0]);
      end
      @(negedge Clk);
      checks++;
      if (zf[0] !== 1'b0 || ov[0] !== 1'b0) begin
         errors++;
         $display("FAIL zero_end: zero=%b valid=%b, want 0 0", zf[0], ov[0]);
      end
   endtask

   task automatic test_clear;
      accept(0, 8'hFF);
      drain(0, 0, 2);
      clr[0] = 1'b1; inv[0] = 1'b1; inp[0] = 8'h0F;
      @(negedge Clk);
      clr[0] = 1'b0; inv[0] = 1'b0;
      q.delete();
      checks++;
      if (ov[0] !== 1'b0 || pc[0] !== 8'd0 || ir[0] !== 1'b1) begin
         errors++;
         $display("FAIL clear_busy: valid=%b cnt=%0d inready=%b, want 0 0 1", ov[0], pc[0], ir[0]);
      end
      // a vector offered alongside Clear in IDLE is lost
      clr[0] = 1'b1; inv[0] = 1'b1; inp[0] = 8'h3C;
      @(negedge Clk);
      clr[0] = 1'b0; inv[0] = 1'b0;
      @(negedge Clk);
      checks++;
      if (ov[0] !== 1'b0 || pc[0] !== 8'd0 || zf[0] !== 1'b0 || ir[0] !== 1'b1) begin
         errors++;
         $display("FAIL clear_idle: valid=%b cnt=%0d zero=%b inready=%b, want 0 0 0 1", ov[0], pc[0], zf[0], ir[0]);
      end
   endtask

   task automatic test_npot;
      int prev;
      for (int b = 0; b < 2; b++) begin
         accept(2, 8'h11);
         drain(2, 0, -1);
      end
      // abort each batch after one grant so LastGrant flips between 4 and 0
      prev = -1;
      for (int b = 0; b < 3; b++) begin
         accept(2, 8'h11);
         checks++;
         if (out_w[2] >= 8'd5 || (prev >= 0 && out_w[2] === 8'(prev))) begin
            errors++;
            $display("FAIL npot_alternate b%0d: first=%0d prev=%0d, want a code <5 differing from prev", b, out_w[2], prev);
         end
         prev = int'(out_w[2]);
         drain(2, 0, 1);
         clr[2] = 1'b1;
         @(negedge Clk);
         clr[2] = 1'b0;
         q.delete();
      end
   endtask

   task automatic test_reset_mid;
      accept(0, 8'hFF);
      drain(0, 0, 2);
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if (ov[0] !== 1'b0 || pc[0] !== 8'd0 || out_w[0] !== 8'd0 || zf[0] !== 1'b0 || ir[0] !== 1'b1) begin
         errors++;
         $display("FAIL reset_mid: valid=%b cnt=%0d out=%0d zero=%b inready=%b, want 0 0 0 0 1",
                  ov[0], pc[0], out_w[0], zf[0], ir[0]);
      end
      q.delete();
      for (int d = 0; d < 3; d++) model_last[d] = 0;
      @(negedge Clk);
      rst_n = 1'b1;
      @(negedge Clk);
      accept(0, 8'hFF);
      drain(0, 0, -1);
      accept(1, 8'h09);
      drain(1, 0, -1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0;
      for (int d = 0; d < 3; d++) begin
         inp[d] = 8'h00; inv[d] = 1'b0; oready[d] = 1'b0; clr[d] = 1'b0;
      end
      test_reset;
      test_fixed_prio;
      test_backpressure;
      test_back_to_back;
      test_round_robin;
      test_zero;
      test_clear;
      test_npot;
      test_reset_mid;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
